// File: rtl/tag_mem_pkg.sv
// Shared types and defaults for the tag cache backing-memory responder.
// The FSM state type, default geometry and the stall LFSR seed live here.
package tag_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RWAIT = 2'd2,
    RDATA = 2'd3
  } tag_mem_state_e;

  localparam int DEF_ADDR_W  = 26;
  localparam int DEF_TAG_W   = 5;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_BEATS   = 4;
  localparam int DEF_LINES   = 1024;
  localparam int DEF_LATENCY = 8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/tag_mem_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) whose bit 0 requests a stall cycle.
// Used by tag_mem_responder only when TAG_MEM_STALL_INJECT_EN is defined.
module tag_mem_lfsr
  import tag_mem_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic clk,
  input  logic reset_n,
  output logic stall
);

  logic [15:0] q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED;
    end else begin
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
  end

  assign stall = q[0];

endmodule

// File: rtl/tag_mem_responder.sv
// Backing-memory model behind the tag cache wrapper: stores whole lines, answers reads
// with tagged multi-beat responses after LATENCY cycles. Define TAG_MEM_STALL_INJECT_EN for LFSR stalls.
module tag_mem_responder
  import tag_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BEATS   = DEF_BEATS,
  parameter int LINES   = DEF_LINES,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [TAG_W-1:0]  cmd_tag,
  input  logic              cmd_rw,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DATA_W-1:0] data_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [TAG_W-1:0]  resp_tag
);

  localparam int LINE_W = $clog2(LINES);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  tag_mem_state_e state, state_nx;
  logic [LINE_W-1:0] line_q, cmd_line, rd_line;
  logic [BEAT_W-1:0] beat_q, rd_beat;
  logic [CNT_W-1:0]  lat_q;
  logic [LINES-1:0]  line_valid;
  logic [DATA_W-1:0] mem [0:LINES*BEATS-1];
  logic cmd_rdy_q, stall, rd_load;
  logic cmd_hs, data_hs, resp_hs;
  logic unused_addr;

`ifdef TAG_MEM_STALL_INJECT_EN
  tag_mem_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .stall   (stall)
  );
`else
  assign stall = 1'b0;
`endif

  // Upper address bits alias onto the same line by design.
  assign cmd_line    = cmd_addr[LINE_W-1:0];
  assign unused_addr = ^cmd_addr[ADDR_W-1:LINE_W];

  assign cmd_ready  = cmd_rdy_q & ~stall;
  assign data_ready = (state == WDATA) & ~stall;
  assign resp_valid = (state == RDATA) & ~stall;

  assign cmd_hs  = cmd_valid & cmd_ready;
  assign data_hs = data_valid & data_ready;
  assign resp_hs = resp_valid & resp_ready;

  always_comb begin
    state_nx = state;
    rd_load  = 1'b0;
    rd_line  = line_q;
    rd_beat  = beat_q + 1'b1;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          if (cmd_rw) begin
            state_nx = WDATA;
          end else if (LATENCY == 1) begin
            state_nx = RDATA;
            rd_load  = 1'b1;
            rd_line  = cmd_line;
            rd_beat  = '0;
          end else begin
            state_nx = RWAIT;
          end
        end
      end
      WDATA: begin
        if (data_hs && beat_q == LAST_BEAT) state_nx = IDLE;
      end
      RWAIT: begin
        if (lat_q == CNT_W'(1)) begin
          state_nx = RDATA;
          rd_load  = 1'b1;
          rd_beat  = '0;
        end
      end
      RDATA: begin
        if (resp_hs) begin
          if (beat_q == LAST_BEAT) state_nx = IDLE;
          else rd_load = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Response data is loaded one beat ahead so it is a flop output and holds under stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd_rdy_q  <= 1'b0;
      line_q     <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
      line_valid <= '0;
      resp_data  <= '0;
      resp_tag   <= '0;
    end else begin
      state     <= state_nx;
      cmd_rdy_q <= (state_nx == IDLE);
      if (cmd_hs) begin
        line_q   <= cmd_line;
        resp_tag <= cmd_tag;
        beat_q   <= '0;
        lat_q    <= LAT_LOAD;
      end
      if (state == RWAIT) lat_q <= lat_q - 1'b1;
      if (data_hs) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == LAST_BEAT) line_valid[line_q] <= 1'b1;
      end
      if (resp_hs) beat_q <= beat_q + 1'b1;
      if (rd_load) resp_data <= line_valid[rd_line] ? mem[{rd_line, rd_beat}] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (data_hs) mem[{line_q, beat_q}] <= data_data;
  end

endmodule

// File: tb/tb_tag_mem_responder.sv
// Self-checking bench for tag_mem_responder: a line-level memory model plus
// response queues checked every cycle, and directed transactions with literal expectations.
module tb_tag_mem_responder;

  localparam int ADDR_W  = 26;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 128;
  localparam int BEATS   = 4;
  localparam int LINES   = 1024;
  localparam int LATENCY = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic cmd_valid, cmd_ready, cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [TAG_W-1:0]  cmd_tag;
  logic data_valid, data_ready;
  logic [DATA_W-1:0] data_data;
  logic resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [DATA_W-1:0] model_mem [LINES][BEATS];
  bit                model_valid [LINES];
  logic [DATA_W-1:0] exp_data [$];
  logic [TAG_W-1:0]  exp_tag [$];
  logic [DATA_W-1:0] got_data [$];
  logic [TAG_W-1:0]  got_tag [$];
  bit wr_active, hold, first_pending;
  int wr_line, wr_beat, rd_cmd_cyc, lat, last_latency;
  logic [DATA_W-1:0] hold_data;
  logic [TAG_W-1:0]  hold_tag;

  tag_mem_responder #(
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W),
    .BEATS(BEATS), .LINES(LINES), .LATENCY(LATENCY)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_tag    (cmd_tag),
    .cmd_rw     (cmd_rw),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_data  (data_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic failNote(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got no progress, expected completion", name);
  endtask

  // Compare process: samples 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!reset_n) begin
      for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
      exp_data.delete();
      exp_tag.delete();
      wr_active = 1'b0;
      hold = 1'b0;
      first_pending = 1'b0;
    end else begin
      if (hold) begin
        checkOutput("hold_data", resp_data, hold_data);
        checkOutput("hold_tag", 128'(resp_tag), 128'(hold_tag));
      end
      if (resp_valid) begin
        if (exp_data.size() == 0) begin
          failNote("unexpected_resp");
        end else begin
          if (first_pending) begin
            lat = cyc - rd_cmd_cyc;
            last_latency = lat;
            first_pending = 1'b0;
`ifdef TAG_MEM_STALL_INJECT_EN
            checkOutput("latency_min", 128'(lat >= LATENCY), 128'(1));
`else
            checkOutput("first_beat_latency", 128'(lat), 128'(LATENCY));
`endif
          end
          checkOutput("resp_data", resp_data, exp_data[0]);
          checkOutput("resp_tag", 128'(resp_tag), 128'(exp_tag[0]));
          if (resp_ready) begin
            got_data.push_back(resp_data);
            got_tag.push_back(resp_tag);
            void'(exp_data.pop_front());
            void'(exp_tag.pop_front());
            hold = 1'b0;
          end else begin
            hold = 1'b1;
            hold_data = resp_data;
            hold_tag = resp_tag;
          end
        end
      end
      if (data_valid && data_ready && wr_active) begin
        model_mem[wr_line][wr_beat] = data_data;
        wr_beat++;
        if (wr_beat == BEATS) begin
          model_valid[wr_line] = 1'b1;
          wr_active = 1'b0;
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (cmd_rw) begin
          wr_active = 1'b1;
          wr_line = int'(cmd_addr % LINES);
          wr_beat = 0;
        end else begin
          for (int b = 0; b < BEATS; b++) begin
            exp_data.push_back(model_valid[cmd_addr % LINES] ? model_mem[cmd_addr % LINES][b] : '0);
            exp_tag.push_back(cmd_tag);
          end
          rd_cmd_cyc = cyc;
          first_pending = 1'b1;
        end
      end
    end
  end

  // One full transaction; writes send base+beat, stopping after abort_after beats.
  task automatic applyStimulus(input logic rw, input logic [ADDR_W-1:0] addr, input logic [TAG_W-1:0] tag,
                               input logic [DATA_W-1:0] base, input int bp_beat, input bit rnd_ready,
                               input int abort_after);
    int guard;
    bit hs, bp_done;
    if (!rw) begin
      got_data.delete();
      got_tag.delete();
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr = addr;
    cmd_tag = tag;
    cmd_rw = rw;
    guard = 0;
    hs = 1'b0;
    while (!hs && guard < 100) begin
      #4 hs = cmd_ready;
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b0;
    if (!hs) begin
      failNote("cmd_timeout");
      return;
    end
    if (rw) begin
      for (int b = 0; b < BEATS && b < abort_after; b++) begin
        data_valid = 1'b1;
        data_data = base + 128'(b);
        guard = 0;
        hs = 1'b0;
        while (!hs && guard < 100) begin
          #4 hs = data_ready;
          @(negedge clk);
          guard++;
        end
        if (!hs) begin
          data_valid = 1'b0;
          failNote("data_timeout");
          return;
        end
      end
      data_valid = 1'b0;
    end else begin
      guard = 0;
      bp_done = 1'b0;
      while (got_data.size() < BEATS && guard < 400) begin
        if (bp_beat >= 0 && !bp_done && got_data.size() == bp_beat) begin
          resp_ready = 1'b0;
          repeat (3) @(negedge clk);
          resp_ready = 1'b1;
          bp_done = 1'b1;
          guard += 3;
        end else begin
          if (rnd_ready) resp_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          guard++;
        end
      end
      resp_ready = 1'b1;
      if (got_data.size() < BEATS) failNote("resp_timeout");
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_tag = '0;
    cmd_rw = 1'b0;
    data_valid = 1'b0;
    data_data = '0;
    resp_ready = 1'b1;

    repeat (2) @(negedge clk);
    #4;
    checkOutput("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    checkOutput("rst_data_ready", 128'(data_ready), 128'(0));
    checkOutput("rst_resp_valid", 128'(resp_valid), 128'(0));
    checkOutput("rst_resp_data", resp_data, 128'(0));
    checkOutput("rst_resp_tag", 128'(resp_tag), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #4;
`ifndef TAG_MEM_STALL_INJECT_EN
    checkOutput("cmd_ready_after_reset", 128'(cmd_ready), 128'(1));
`endif

    $display("[TB] reset read of 0x10");
    applyStimulus(1'b0, 26'h10, 5'd3, '0, -1, 1'b0, BEATS);
    checkOutput("reset_read_count", 128'(got_data.size()), 128'(4));
    for (int i = 0; i < got_data.size(); i++) begin
      checkOutput("reset_read_data", got_data[i], 128'(0));
      checkOutput("reset_read_tag", 128'(got_tag[i]), 128'(3));
    end
`ifndef TAG_MEM_STALL_INJECT_EN
    checkOutput("reset_read_latency", 128'(last_latency), 128'(8));
`endif

    $display("[TB] write then read of 0x10");
    applyStimulus(1'b1, 26'h10, 5'd5, 128'hA0, -1, 1'b0, BEATS);
    applyStimulus(1'b0, 26'h10, 5'd7, '0, -1, 1'b0, BEATS);
    checkOutput("wr_rd_count", 128'(got_data.size()), 128'(4));
    for (int i = 0; i < got_data.size(); i++) begin
      checkOutput("wr_rd_data", got_data[i], 128'hA0 + 128'(i));
      checkOutput("wr_rd_tag", 128'(got_tag[i]), 128'(7));
    end

    $display("[TB] aliasing 0x005 / 0x405");
    applyStimulus(1'b1, 26'h005, 5'd1, 128'h11, -1, 1'b0, BEATS);
    applyStimulus(1'b1, 26'h405, 5'd2, 128'h22, -1, 1'b0, BEATS);
    applyStimulus(1'b0, 26'h005, 5'd4, '0, -1, 1'b0, BEATS);
    checkOutput("alias_count", 128'(got_data.size()), 128'(4));
    for (int i = 0; i < got_data.size(); i++) begin
      checkOutput("alias_data", got_data[i], 128'h22 + 128'(i));
    end

    $display("[TB] backpressure on beat 1");
    applyStimulus(1'b0, 26'h10, 5'd9, '0, 1, 1'b0, BEATS);
    checkOutput("bp_count", 128'(got_data.size()), 128'(4));
    for (int i = 0; i < got_data.size(); i++) begin
      checkOutput("bp_data", got_data[i], 128'hA0 + 128'(i));
      checkOutput("bp_tag", 128'(got_tag[i]), 128'(9));
    end

    $display("[TB] reset during write to 0x20");
    applyStimulus(1'b1, 26'h20, 5'd6, 128'hB0, -1, 1'b0, 2);
    reset_n = 1'b0;
    #4;
    checkOutput("mid_reset_cmd_ready", 128'(cmd_ready), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #4;
`ifndef TAG_MEM_STALL_INJECT_EN
    checkOutput("cmd_ready_after_mid_reset", 128'(cmd_ready), 128'(1));
`endif
    applyStimulus(1'b0, 26'h20, 5'd8, '0, -1, 1'b0, BEATS);
    checkOutput("partial_line_count", 128'(got_data.size()), 128'(4));
    for (int i = 0; i < got_data.size(); i++) begin
      checkOutput("partial_line_data", got_data[i], 128'(0));
    end
    applyStimulus(1'b0, 26'h10, 5'd10, '0, -1, 1'b0, BEATS);
    for (int i = 0; i < got_data.size(); i++) begin
      checkOutput("cleared_line_data", got_data[i], 128'(0));
    end

    $display("[TB] 200 random transactions");
    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ADDR_W'($urandom_range(0, 3) * 1024 + $urandom_range(0, 7)),
                    TAG_W'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, -1, 1'b1, BEATS);
    end

    repeat (4) @(negedge clk);
    checkOutput("leftover_beats", 128'(exp_data.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
